// File: rtl/snn_image_sender_if.sv
// Bus bundle between the image sender and its RAM, uart_tx, uart_rx and host.
interface snn_image_sender_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_q;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_rdy;
  logic                  rx_rdy;
  logic [7:0]            rx_data;
  logic                  busy;
  logic                  done;
  logic [3:0]            digit;
  logic                  err;

  modport master (
    input  start, ram_q, tx_rdy, rx_rdy, rx_data,
    output ram_addr, tx_start, tx_data, busy, done, digit, err
  );

  modport slave (
    output start, ram_q, tx_rdy, rx_rdy, rx_data,
    input  ram_addr, tx_start, tx_data, busy, done, digit, err
  );
endinterface

// File: rtl/snn_image_sender.sv
// Host-side initiator for the SNN UART image protocol: streams a 1-bpp image
// from RAM as LSB-first packed bytes, then waits for the classified digit.
module snn_image_sender #(
  parameter int NUM_PIXELS     = 784,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  snn_image_sender_if.master  bus
);
  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int BW        = $clog2(NUM_BYTES + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_TX, WAIT_RESULT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [2:0]            bit_cnt;
  logic [BW-1:0]         byte_cnt;
  logic [7:0]            shift;
  logic                  primed;
  logic                  tx_first;
  logic [TW-1:0]         tcnt;
  logic                  tx_start_r;
  logic [7:0]            tx_data_r;
  logic                  busy_r;
  logic                  done_r;
  logic [3:0]            digit_r;
  logic                  err_r;

  assign bus.ram_addr = pix_cnt;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.digit    = digit_r;
  assign bus.err      = err_r;

  // Main protocol FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      primed     <= 1'b0;
      tx_first   <= 1'b0;
      tcnt       <= '0;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      digit_r    <= '0;
      err_r      <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FETCH;
            pix_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            primed   <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        FETCH: begin
          // The address stops advancing after the 8th pixel of the byte so it
          // never runs past the last pixel; WAIT_TX steps it to the next byte.
          if (!primed || bit_cnt < 3'd6) pix_cnt <= pix_cnt + 1'b1;
          if (!primed) begin
            primed <= 1'b1;
          end else begin
            shift[bit_cnt] <= bus.ram_q;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              primed  <= 1'b0;
              state   <= SEND;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        SEND: begin
          if (bus.tx_rdy) begin
            tx_data_r  <= shift;
            tx_start_r <= 1'b1;
            tx_first   <= 1'b1;
            state      <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_first) begin
            tx_first <= 1'b0;
          end else if (bus.tx_rdy) begin
            if (byte_cnt == BW'(NUM_BYTES - 1)) begin
              tcnt  <= '0;
              state <= WAIT_RESULT;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              pix_cnt  <= pix_cnt + 1'b1;
              state    <= FETCH;
            end
          end
        end
        WAIT_RESULT: begin
          if (bus.rx_rdy) begin
            if (bus.rx_data <= 8'd9) begin
              digit_r <= bus.rx_data[3:0];
              done_r  <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err_r  <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_image_sender.sv
// Self-checking bench for snn_image_sender: RAM, uart_tx and uart_rx models
// plus a packed-byte reference computed from the image contents.
module tb_snn_image_sender;
  localparam int NUM_PIXELS = 784;
  localparam int NUM_BYTES  = NUM_PIXELS / 8;
  localparam int TIMEOUT    = 1000;
  localparam int AW         = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snn_image_sender_if #(.ADDR_WIDTH(AW)) bus();

  snn_image_sender #(
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int max_addr;
  logic [3:0] model_digit;
  logic mem [0:NUM_PIXELS-1];
  logic [7:0] tx_q[$];
  int tx_hold;

  typedef struct {
    int         pat;        // 0 zeros, 1 diagonal, 2 random
    int         reply_at;   // cycle after WAIT_RESULT entry, -1 = never
    logic [7:0] reply;
    bit         spur;       // spurious rx_rdy during the transfer
    bit         dbl;        // extra start pulse during the transfer
    bit         exp_done;
    bit         exp_err;
    logic [3:0] exp_digit;
    int         exp_n;      // cycles from entry to done/err
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Synchronous image RAM: data one cycle after the address.
  always @(posedge clk) begin
    if (int'(bus.ram_addr) < NUM_PIXELS) bus.ram_q <= mem[bus.ram_addr];
    else bus.ram_q <= 1'b0;
  end

  // uart_tx model: busy for a random number of cycles after each tx_start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_rdy <= 1'b1;
      tx_hold    <= 0;
    end else if (bus.tx_start) begin
      bus.tx_rdy <= 1'b0;
      tx_hold    <= $urandom_range(1, 5);
      tx_q.push_back(bus.tx_data);
    end else if (tx_hold > 1) begin
      tx_hold <= tx_hold - 1;
    end else if (tx_hold == 1) begin
      tx_hold    <= 0;
      bus.tx_rdy <= 1'b1;
    end
  end

  // Protocol monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.tx_start) check("tx_start_while_tx_busy", 32'(bus.tx_rdy), 1);
      if (bus.done || bus.err) check("done_err_exclusive", 32'(bus.done & bus.err), 0);
      if (bus.busy && int'(bus.ram_addr) > max_addr) max_addr = int'(bus.ram_addr);
    end
  end

  function automatic logic [7:0] exp_byte(input int k);
    int v = 0;
    for (int i = 0; i < 8; i++) v += mem[8*k+i] ? (1 << i) : 0;
    return v[7:0];
  endfunction

  task automatic fill_mem(input int pat);
    for (int p = 0; p < NUM_PIXELS; p++) begin
      case (pat)
        0:       mem[p] = 1'b0;
        1:       mem[p] = ((p % 8) == ((p / 8) % 8));
        default: mem[p] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic run_image(input vec_t v);
    int guard = 0;
    int n = 0;
    int spur_cd = -1;
    bit spur_done = 0;
    bit dbl_done = 0;
    fill_mem(v.pat);
    tx_q.delete();
    max_addr = 0;
    pulse_start();
    check("busy_after_start", 32'(bus.busy), 1);
    while (!(tx_q.size() == NUM_BYTES && bus.tx_rdy) && guard < 20000) begin
      bus.rx_rdy = 1'b0;
      bus.start  = 1'b0;
      if (v.spur && !spur_done && tx_q.size() == 5 && bus.tx_rdy) begin
        spur_cd   = 3;
        spur_done = 1;
      end
      if (spur_cd == 0) begin
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h07;
      end
      if (spur_cd >= 0) spur_cd--;
      if (v.dbl && !dbl_done && tx_q.size() == 20) begin
        bus.start = 1'b1;
        dbl_done  = 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.rx_rdy = 1'b0;
    bus.start  = 1'b0;
    check("byte_phase_in_budget", 32'(guard < 20000), 1);
    check("byte_count", tx_q.size(), NUM_BYTES);
    for (int k = 0; k < NUM_BYTES && k < tx_q.size(); k++)
      check($sformatf("byte[%0d]", k), 32'(tx_q[k]), 32'(exp_byte(k)));
    check("max_ram_addr", max_addr, NUM_PIXELS - 1);
    check("digit_held_during_transfer", 32'(bus.digit), 32'(model_digit));
    check("busy_during_transfer", 32'(bus.busy), 1);
    // Next edge enters WAIT_RESULT; n counts cycles from that entry.
    @(posedge clk); #1;
    while (!(bus.done || bus.err) && n < TIMEOUT + 50) begin
      bus.rx_rdy  = (n == v.reply_at);
      bus.rx_data = v.reply;
      @(posedge clk); #1;
      n++;
    end
    bus.rx_rdy = 1'b0;
    check("result_latency", n, v.exp_n);
    check("done", 32'(bus.done), 32'(v.exp_done));
    check("err", 32'(bus.err), 32'(v.exp_err));
    check("digit", 32'(bus.digit), 32'(v.exp_digit));
    check("busy_after_result", 32'(bus.busy), 0);
    model_digit = v.exp_digit;
    @(posedge clk); #1;
    check("result_pulse_one_cycle", 32'(bus.done | bus.err), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    check({tag, "_tx_data"},  32'(bus.tx_data), 0);
    check({tag, "_busy"},     32'(bus.busy), 0);
    check({tag, "_done"},     32'(bus.done), 0);
    check({tag, "_digit"},    32'(bus.digit), 0);
    check({tag, "_err"},      32'(bus.err), 0);
  endtask

  initial begin
    vec_t fin;
    int guard;
    logic [7:0] r;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    model_digit = 4'd0;
    max_addr    = 0;

    tbl[0] = '{0,  5,  8'h03, 0, 0, 1, 0, 4'd3, 6};
    tbl[1] = '{1,  0,  8'h05, 0, 0, 1, 0, 4'd5, 1};
    tbl[2] = '{2, -1,  8'h00, 0, 0, 0, 1, 4'd5, TIMEOUT};
    tbl[3] = '{2, 10,  8'h0C, 1, 0, 0, 1, 4'd5, 11};
    tbl[4] = '{2, TIMEOUT-1, 8'h09, 0, 1, 1, 0, 4'd9, TIMEOUT};
    tbl[5] = '{1,  3,  8'h0A, 0, 0, 0, 1, 4'd9, 4};
    tbl[6] = '{2,  7,  8'h00, 1, 1, 1, 0, 4'd0, 8};
    for (int i = 7; i < 10; i++) begin
      r = 8'($urandom_range(0, 15));
      tbl[i].pat       = 2;
      tbl[i].reply_at  = $urandom_range(0, 60);
      tbl[i].reply     = r;
      tbl[i].spur      = 1'($urandom_range(0, 1));
      tbl[i].dbl       = 1'($urandom_range(0, 1));
      tbl[i].exp_done  = (r <= 8'd9);
      tbl[i].exp_err   = (r > 8'd9);
      tbl[i].exp_digit = (r <= 8'd9) ? r[3:0] : tbl[i-1].exp_digit;
      tbl[i].exp_n     = tbl[i].reply_at + 1;
    end

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_image(tbl[i]);

    // Abort mid-transfer at byte 40, then a clean image must follow.
    fill_mem(2);
    tx_q.delete();
    pulse_start();
    guard = 0;
    while (tx_q.size() < 40 && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reached_byte_40", 32'(tx_q.size()), 40);
    rst_n = 1'b0;
    #2 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_digit = 4'd0;
    fin = '{2, 12, 8'h07, 0, 0, 1, 0, 4'd7, 13};
    run_image(fin);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
